// File: rtl/mbtrain_sb_pkg.sv
// mbtrain_sb_pkg: shared wrapper message codes, UCIe MsgCodes, FSM states and encoding helpers
//   Used by mbtrain_sb_tx_adapter (and its optional sb_timeout_counter).
package mbtrain_sb_pkg;

    localparam logic [3:0] MSG_NONE       = 4'd0;
    localparam logic [3:0] MSG_START_REQ  = 4'd1;
    localparam logic [3:0] MSG_START_RESP = 4'd2;
    localparam logic [3:0] MSG_END_REQ    = 4'd3;
    localparam logic [3:0] MSG_END_RESP   = 4'd4;

    localparam logic [7:0] SB_MSGCODE_REQ  = 8'h85;
    localparam logic [7:0] SB_MSGCODE_RESP = 8'h8A;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DONE = 2'd2
    } sb_state_t;

    function automatic logic is_legal_msg(input logic [3:0] msg);
        return (msg != MSG_NONE) && (msg <= MSG_END_RESP);
    endfunction

    function automatic logic [7:0] msg_code_of(input logic [3:0] msg);
        return (msg == MSG_START_REQ || msg == MSG_END_REQ) ? SB_MSGCODE_REQ : SB_MSGCODE_RESP;
    endfunction

    // Substate sits in the upper nibble, bit 0 flags an end_* message.
    function automatic logic [7:0] msg_subcode_of(input logic [3:0] msg, input logic [3:0] substate);
        return {substate, 3'b000, (msg == MSG_END_REQ || msg == MSG_END_RESP)};
    endfunction

endpackage

// File: rtl/sb_timeout_counter.sv
// sb_timeout_counter: 16-bit cycle counter with synchronous clear and one-cycle expiry flag
//   clk, rst_n (sync, active-low)
//   i_clear  : hold count at zero
//   i_en     : count this cycle
//   o_expire : high in the LIMIT-th counted cycle (count == LIMIT-1 while enabled)
module sb_timeout_counter #(
    parameter logic [15:0] LIMIT = 16'd8000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + 16'd1;
    end

    assign o_expire = i_en && (r_count == LIMIT - 16'd1);

endmodule

// File: rtl/mbtrain_sb_tx_adapter.sv
// mbtrain_sb_tx_adapter: maps MBTRAIN wrapper message requests to sideband MsgCode/MsgSubcode and handshakes them out
//   clk, rst_n (sync, active-low)
//   i_en, i_substate[3:0], i_sideband_message[3:0], i_valid : wrapper request side
//   i_sb_ready, i_sb_done                                   : sideband TX handshake
//   o_msg_code[7:0], o_msg_subcode[7:0], o_msg_req          : sideband TX request
//   o_busy, o_falling_edge_busy, o_err, o_timeout           : status back to the wrappers
//   Optional macro MBTRAIN_SB_TIMEOUT_EN enables the WAIT_DONE timeout (TIMEOUT_CYCLES).
module mbtrain_sb_tx_adapter
    import mbtrain_sb_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd8000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [3:0] i_substate,
    input  logic [3:0] i_sideband_message,
    input  logic       i_valid,
    input  logic       i_sb_ready,
    input  logic       i_sb_done,
    output logic [7:0] o_msg_code,
    output logic [7:0] o_msg_subcode,
    output logic       o_msg_req,
    output logic       o_busy,
    output logic       o_falling_edge_busy,
    output logic       o_err,
    output logic       o_timeout
);

    sb_state_t  r_state;
    logic [7:0] r_msg_code;
    logic [7:0] r_msg_subcode;
    logic       r_req;
    logic       r_busy;
    logic       r_fall;
    logic       r_err;
    logic       r_timeout;
    logic       w_expire;

`ifdef MBTRAIN_SB_TIMEOUT_EN
    sb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state != ST_WAIT_DONE),
        .i_en     (r_state == ST_WAIT_DONE),
        .o_expire (w_expire)
    );
`else
    logic [15:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_msg_code    <= '0;
            r_msg_subcode <= '0;
            r_req         <= 1'b0;
            r_busy        <= 1'b0;
            r_fall        <= 1'b0;
            r_err         <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_fall    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            // Abort: drop everything silently so wrappers do not advance.
            if (!i_en) begin
                r_state <= ST_IDLE;
                r_req   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_valid && is_legal_msg(i_sideband_message)) begin
                            r_msg_code    <= msg_code_of(i_sideband_message);
                            r_msg_subcode <= msg_subcode_of(i_sideband_message, i_substate);
                            r_req         <= 1'b1;
                            r_busy        <= 1'b1;
                            r_state       <= ST_REQ;
                        end else if (i_valid && i_sideband_message != MSG_NONE) begin
                            r_err <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (i_sb_ready) begin
                            r_req   <= 1'b0;
                            r_state <= ST_WAIT_DONE;
                        end
                    end
                    ST_WAIT_DONE: begin
                        // Completion beats a timeout landing in the same cycle.
                        if (i_sb_done) begin
                            r_busy  <= 1'b0;
                            r_fall  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (w_expire) begin
                            r_busy    <= 1'b0;
                            r_timeout <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_msg_code          = r_msg_code;
    assign o_msg_subcode       = r_msg_subcode;
    assign o_msg_req           = r_req;
    assign o_busy              = r_busy;
    assign o_falling_edge_busy = r_fall;
    assign o_err               = r_err;
    assign o_timeout           = r_timeout;

endmodule
